// File: rtl/cpu_fetch_ctrl.sv
// Instruction-fetch sequencing controller: owns the PC, streams hits to decode,
// runs I-cache line refills on a miss and parks on I-TLB faults.
module cpu_fetch_ctrl #(
  parameter int unsigned         PC_WIDTH    = 20,
  parameter int unsigned         INSTR_WIDTH = 32,
  parameter int unsigned         LINE_WIDTH  = 128,
  parameter logic [PC_WIDTH-1:0] BOOT_PC     = 20'h01000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   priv_i,
  input  logic                   stall_i,
  input  logic                   redirect_valid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic [PC_WIDTH-1:0]    pc_o,
  output logic                   tlb_enable_o,
  input  logic                   tlb_hit_i,
  input  logic                   cache_hit_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  output logic                   fetch_valid_o,
  output logic [INSTR_WIDTH-1:0] fetch_instr_o,
  output logic [PC_WIDTH-1:0]    fetch_pc_o,
  output logic                   itlb_fault_o,
  output logic [PC_WIDTH-1:0]    fault_pc_o,
  output logic                   mem_req_valid_o,
  output logic [PC_WIDTH-1:0]    mem_req_addr_o,
  input  logic                   mem_req_ready_i,
  input  logic                   mem_resp_valid_i,
  input  logic [LINE_WIDTH-1:0]  mem_resp_data_i,
  output logic                   fill_o,
  output logic [PC_WIDTH-1:0]    fill_addr_o,
  output logic [LINE_WIDTH-1:0]  fill_data_o,
  output logic [15:0]            miss_count_o
);

  localparam int unsigned         OFF_BITS  = $clog2(LINE_WIDTH / 8);
  localparam logic [PC_WIDTH-1:0] LINE_MASK = ~((PC_WIDTH'(1) << OFF_BITS) - PC_WIDTH'(1));
  localparam logic [PC_WIDTH-1:0] PC_STEP   = PC_WIDTH'(INSTR_WIDTH / 8);

  typedef enum logic [2:0] {
    S_RUN,
    S_MISS_REQ,
    S_MISS_WAIT,
    S_REPLAY,
    S_FAULT
  } state_e;

  state_e                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   fetch_valid_q, fetch_valid_d;
  logic [INSTR_WIDTH-1:0] fetch_instr_q, fetch_instr_d;
  logic [PC_WIDTH-1:0]    fetch_pc_q, fetch_pc_d;
  logic                   itlb_fault_q, itlb_fault_d;
  logic [PC_WIDTH-1:0]    fault_pc_q, fault_pc_d;
  logic                   req_valid_q, req_valid_d;
  logic [PC_WIDTH-1:0]    miss_addr_q, miss_addr_d;
  logic                   fill_q, fill_d;
  logic [PC_WIDTH-1:0]    fill_addr_q, fill_addr_d;
  logic [LINE_WIDTH-1:0]  fill_data_q, fill_data_d;
  logic [15:0]            miss_count_q, miss_count_d;
  logic                   pend_q, pend_d;
  logic [PC_WIDTH-1:0]    pend_pc_q, pend_pc_d;
  logic                   tlb_en;

  // Translation is only used outside privileged mode.
  assign tlb_en       = ~priv_i;
  assign tlb_enable_o = tlb_en;

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_RUN;
      pc_q          <= BOOT_PC;
      fetch_valid_q <= 1'b0;
      fetch_instr_q <= '0;
      fetch_pc_q    <= '0;
      itlb_fault_q  <= 1'b0;
      fault_pc_q    <= '0;
      req_valid_q   <= 1'b0;
      miss_addr_q   <= '0;
      fill_q        <= 1'b0;
      fill_addr_q   <= '0;
      fill_data_q   <= '0;
      miss_count_q  <= '0;
      pend_q        <= 1'b0;
      pend_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_instr_q <= fetch_instr_d;
      fetch_pc_q    <= fetch_pc_d;
      itlb_fault_q  <= itlb_fault_d;
      fault_pc_q    <= fault_pc_d;
      req_valid_q   <= req_valid_d;
      miss_addr_q   <= miss_addr_d;
      fill_q        <= fill_d;
      fill_addr_q   <= fill_addr_d;
      fill_data_q   <= fill_data_d;
      miss_count_q  <= miss_count_d;
      pend_q        <= pend_d;
      pend_pc_q     <= pend_pc_d;
    end
  end

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_valid_d = fetch_valid_q;
    fetch_instr_d = fetch_instr_q;
    fetch_pc_d    = fetch_pc_q;
    itlb_fault_d  = 1'b0;
    fault_pc_d    = fault_pc_q;
    req_valid_d   = 1'b0;
    miss_addr_d   = miss_addr_q;
    fill_d        = 1'b0;
    fill_addr_d   = fill_addr_q;
    fill_data_d   = fill_data_q;
    miss_count_d  = miss_count_q;
    pend_d        = pend_q;
    pend_pc_d     = pend_pc_q;

    unique case (state_q)
      S_RUN: begin
        if (redirect_valid_i) begin
          pc_d          = redirect_pc_i;
          fetch_valid_d = 1'b0;
        end else if (stall_i) begin
          // decode backpressure: hold PC and fetch outputs
        end else if (tlb_en && !tlb_hit_i) begin
          itlb_fault_d  = 1'b1;
          fault_pc_d    = pc_q;
          fetch_valid_d = 1'b0;
          state_d       = S_FAULT;
        end else if (!cache_hit_i) begin
          miss_addr_d   = pc_q & LINE_MASK;
          miss_count_d  = miss_count_q + 16'd1;
          fetch_valid_d = 1'b0;
          req_valid_d   = 1'b1;
          state_d       = S_MISS_REQ;
        end else begin
          fetch_valid_d = 1'b1;
          fetch_instr_d = instr_i;
          fetch_pc_d    = pc_q;
          pc_d          = pc_q + PC_STEP;
        end
      end

      S_MISS_REQ: begin
        fetch_valid_d = 1'b0;
        req_valid_d   = 1'b1;
        if (mem_req_ready_i) begin
          // accepted; a coincident redirect is deferred until the refill lands
          req_valid_d = 1'b0;
          state_d     = S_MISS_WAIT;
          if (redirect_valid_i) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc_i;
          end
        end else if (redirect_valid_i) begin
          req_valid_d = 1'b0;
          pc_d        = redirect_pc_i;
          state_d     = S_RUN;
        end
      end

      S_MISS_WAIT: begin
        fetch_valid_d = 1'b0;
        if (redirect_valid_i) begin
          pend_d    = 1'b1;
          pend_pc_d = redirect_pc_i;
        end
        if (mem_resp_valid_i) begin
          fill_d      = 1'b1;
          fill_addr_d = miss_addr_q;
          fill_data_d = mem_resp_data_i;
          state_d     = S_REPLAY;
        end
      end

      S_REPLAY: begin
        fetch_valid_d = 1'b0;
        pend_d        = 1'b0;
        state_d       = S_RUN;
        if (redirect_valid_i) begin
          pc_d = redirect_pc_i;
        end else if (pend_q) begin
          pc_d = pend_pc_q;
        end
      end

      S_FAULT: begin
        fetch_valid_d = 1'b0;
        if (redirect_valid_i) begin
          pc_d    = redirect_pc_i;
          state_d = S_RUN;
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  assign pc_o            = pc_q;
  assign fetch_valid_o   = fetch_valid_q;
  assign fetch_instr_o   = fetch_instr_q;
  assign fetch_pc_o      = fetch_pc_q;
  assign itlb_fault_o    = itlb_fault_q;
  assign fault_pc_o      = fault_pc_q;
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_addr_o  = miss_addr_q;
  assign fill_o          = fill_q;
  assign fill_addr_o     = fill_addr_q;
  assign fill_data_o     = fill_data_q;
  assign miss_count_o    = miss_count_q;

endmodule

// File: tb/tb_cpu_fetch_ctrl.sv
// Bench for cpu_fetch_ctrl: vector table, directed miss/fault/reset sequences,
// then random traffic against a transaction-level reference model.
module tb_cpu_fetch_ctrl;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         priv_i, stall_i, redirect_valid_i;
  logic [19:0]  redirect_pc_i;
  logic [19:0]  pc_o;
  logic         tlb_enable_o, tlb_hit_i, cache_hit_i;
  logic [31:0]  instr_i;
  logic         fetch_valid_o;
  logic [31:0]  fetch_instr_o;
  logic [19:0]  fetch_pc_o;
  logic         itlb_fault_o;
  logic [19:0]  fault_pc_o;
  logic         mem_req_valid_o;
  logic [19:0]  mem_req_addr_o;
  logic         mem_req_ready_i, mem_resp_valid_i;
  logic [127:0] mem_resp_data_i;
  logic         fill_o;
  logic [19:0]  fill_addr_o;
  logic [127:0] fill_data_o;
  logic [15:0]  miss_count_o;

  int total = 0;
  int bad   = 0;

  cpu_fetch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .priv_i(priv_i), .stall_i(stall_i),
    .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
    .pc_o(pc_o), .tlb_enable_o(tlb_enable_o), .tlb_hit_i(tlb_hit_i),
    .cache_hit_i(cache_hit_i), .instr_i(instr_i), .fetch_valid_o(fetch_valid_o),
    .fetch_instr_o(fetch_instr_o), .fetch_pc_o(fetch_pc_o),
    .itlb_fault_o(itlb_fault_o), .fault_pc_o(fault_pc_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_ready_i(mem_req_ready_i), .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_data_i(mem_resp_data_i), .fill_o(fill_o), .fill_addr_o(fill_addr_o),
    .fill_data_o(fill_data_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_in();
    priv_i = 1'b1; stall_i = 1'b0; redirect_valid_i = 1'b0; redirect_pc_i = '0;
    tlb_hit_i = 1'b1; cache_hit_i = 1'b1; instr_i = '0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_data_i = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    idle_in();
    step();
    step();
    reset_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        priv, stall, redir;
    logic [19:0] rpc;
    logic        thit, chit;
    logic [31:0] instr;
    logic [19:0] e_pc;
    logic        e_valid;
    logic [19:0] e_fpc;
    logic [31:0] e_instr;
    logic        e_fault;
    logic [19:0] e_fltpc;
  } vec_t;

  function automatic vec_t mk(logic p, logic s, logic r, logic [19:0] rpc, logic th, logic ch,
                              logic [31:0] ins, logic [19:0] epc, logic ev, logic [19:0] efpc,
                              logic [31:0] eins, logic ef, logic [19:0] efl);
    vec_t v;
    v.priv = p; v.stall = s; v.redir = r; v.rpc = rpc; v.thit = th; v.chit = ch;
    v.instr = ins; v.e_pc = epc; v.e_valid = ev; v.e_fpc = efpc; v.e_instr = eins;
    v.e_fault = ef; v.e_fltpc = efl;
    return v;
  endfunction

  // ---------------- reference model ----------------
  localparam int M_RUN = 0, M_REQ = 1, M_WAIT = 2, M_REPLAY = 3, M_FAULT = 4;
  int           m_ph;
  logic [19:0]  m_pc, m_fp, m_fltpc, m_raddr, m_faddr, m_ppc;
  logic [31:0]  m_fi;
  logic [127:0] m_fdata;
  logic         m_fv, m_flt, m_rv, m_fill, m_pend;
  logic [15:0]  m_cnt;

  task automatic model_reset();
    m_ph = M_RUN; m_pc = 20'h01000; m_fp = '0; m_fi = '0; m_fv = 1'b0;
    m_flt = 1'b0; m_fltpc = '0; m_rv = 1'b0; m_raddr = '0; m_fill = 1'b0;
    m_faddr = '0; m_fdata = '0; m_cnt = '0; m_pend = 1'b0; m_ppc = '0;
  endtask

  // Predict the outputs after the next clock edge from the currently driven inputs.
  task automatic model_step();
    m_flt  = 1'b0;
    m_fill = 1'b0;
    case (m_ph)
      M_RUN: begin
        if (redirect_valid_i) begin
          m_pc = redirect_pc_i; m_fv = 1'b0;
        end else if (stall_i) begin
          m_pc = m_pc;
        end else if (!priv_i && !tlb_hit_i) begin
          m_flt = 1'b1; m_fltpc = m_pc; m_fv = 1'b0; m_ph = M_FAULT;
        end else if (!cache_hit_i) begin
          m_raddr = {m_pc[19:4], 4'h0}; m_cnt = m_cnt + 16'd1; m_fv = 1'b0; m_ph = M_REQ;
        end else begin
          m_fv = 1'b1; m_fi = instr_i; m_fp = m_pc; m_pc = m_pc + 20'd4;
        end
      end
      M_REQ: begin
        if (mem_req_ready_i) begin
          m_ph = M_WAIT;
          if (redirect_valid_i) begin m_pend = 1'b1; m_ppc = redirect_pc_i; end
        end else if (redirect_valid_i) begin
          m_pc = redirect_pc_i; m_ph = M_RUN;
        end
      end
      M_WAIT: begin
        if (redirect_valid_i) begin m_pend = 1'b1; m_ppc = redirect_pc_i; end
        if (mem_resp_valid_i) begin
          m_fill = 1'b1; m_faddr = m_raddr; m_fdata = mem_resp_data_i; m_ph = M_REPLAY;
        end
      end
      M_REPLAY: begin
        if (redirect_valid_i) m_pc = redirect_pc_i;
        else if (m_pend) m_pc = m_ppc;
        m_pend = 1'b0;
        m_ph = M_RUN;
      end
      default: begin
        if (redirect_valid_i) begin m_pc = redirect_pc_i; m_ph = M_RUN; end
      end
    endcase
    m_rv = (m_ph == M_REQ);
  endtask

  task automatic model_check();
    chk("r_pc", pc_o, m_pc);
    chk("r_valid", fetch_valid_o, m_fv);
    chk("r_fpc", fetch_pc_o, m_fp);
    chk("r_instr", fetch_instr_o, m_fi);
    chk("r_fault", itlb_fault_o, m_flt);
    chk("r_fault_pc", fault_pc_o, m_fltpc);
    chk("r_req_valid", mem_req_valid_o, m_rv);
    if (m_rv) chk("r_req_addr", mem_req_addr_o, m_raddr);
    chk("r_fill", fill_o, m_fill);
    if (m_fill) begin
      chk("r_fill_addr", fill_addr_o, m_faddr);
      chk("r_fill_data", fill_data_o, m_fdata);
    end
    chk("r_miss_count", miss_count_o, m_cnt);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[12];
    logic [127:0] d_line, e_line;

    vecs[0]  = mk(1,0,0,20'h0,    1,1,32'h11111111, 20'h01004,1,20'h01000,32'h11111111,0,20'h0);
    vecs[1]  = mk(1,0,0,20'h0,    1,1,32'h22222222, 20'h01008,1,20'h01004,32'h22222222,0,20'h0);
    vecs[2]  = mk(1,1,0,20'h0,    1,1,32'h33333333, 20'h01008,1,20'h01004,32'h22222222,0,20'h0);
    vecs[3]  = mk(1,1,1,20'h05000,1,1,32'h44444444, 20'h05000,0,20'h01004,32'h22222222,0,20'h0);
    vecs[4]  = mk(1,0,0,20'h0,    1,1,32'h55555555, 20'h05004,1,20'h05000,32'h55555555,0,20'h0);
    vecs[5]  = mk(0,0,0,20'h0,    1,1,32'h66666666, 20'h05008,1,20'h05004,32'h66666666,0,20'h0);
    vecs[6]  = mk(1,0,0,20'h0,    0,1,32'h77777777, 20'h0500C,1,20'h05008,32'h77777777,0,20'h0);
    vecs[7]  = mk(0,0,0,20'h0,    0,1,32'h88888888, 20'h0500C,0,20'h05008,32'h77777777,1,20'h0500C);
    vecs[8]  = mk(0,0,0,20'h0,    1,1,32'h99999999, 20'h0500C,0,20'h05008,32'h77777777,0,20'h0500C);
    vecs[9]  = mk(1,0,1,20'hFFFFC,1,1,32'h0,        20'hFFFFC,0,20'h05008,32'h77777777,0,20'h0500C);
    vecs[10] = mk(1,0,0,20'h0,    1,1,32'hAAAAAAAA, 20'h00000,1,20'hFFFFC,32'hAAAAAAAA,0,20'h0500C);
    vecs[11] = mk(0,1,0,20'h0,    0,1,32'hBBBBBBBB, 20'h00000,1,20'hFFFFC,32'hAAAAAAAA,0,20'h0500C);

    @(negedge clk);
    do_reset();
    chk("rst_pc", pc_o, 20'h01000);
    chk("rst_valid", fetch_valid_o, 1'b0);
    chk("rst_fault", itlb_fault_o, 1'b0);
    chk("rst_fault_pc", fault_pc_o, 20'h0);
    chk("rst_req", mem_req_valid_o, 1'b0);
    chk("rst_fill", fill_o, 1'b0);
    chk("rst_count", miss_count_o, 16'h0);

    // table-driven vectors
    for (int i = 0; i < 12; i++) begin
      priv_i = vecs[i].priv; stall_i = vecs[i].stall; redirect_valid_i = vecs[i].redir;
      redirect_pc_i = vecs[i].rpc; tlb_hit_i = vecs[i].thit; cache_hit_i = vecs[i].chit;
      instr_i = vecs[i].instr;
      #1;
      chk($sformatf("v%0d_tlb_en", i), tlb_enable_o, !vecs[i].priv);
      step();
      chk($sformatf("v%0d_pc", i), pc_o, vecs[i].e_pc);
      chk($sformatf("v%0d_valid", i), fetch_valid_o, vecs[i].e_valid);
      chk($sformatf("v%0d_fpc", i), fetch_pc_o, vecs[i].e_fpc);
      chk($sformatf("v%0d_instr", i), fetch_instr_o, vecs[i].e_instr);
      chk($sformatf("v%0d_fault", i), itlb_fault_o, vecs[i].e_fault);
      chk($sformatf("v%0d_fault_pc", i), fault_pc_o, vecs[i].e_fltpc);
    end

    // miss at 0x01008, ready after 2 cycles, response later
    do_reset();
    d_line = 128'hD0D1D2D3_D4D5D6D7_D8D9DADB_DCDDDEDF;
    e_line = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;
    step(); step();
    chk("m_pc_pre", pc_o, 20'h01008);
    chk("m_fpc_lag", fetch_pc_o, 20'h01004);
    cache_hit_i = 1'b0; step(); cache_hit_i = 1'b1;
    chk("m_req", mem_req_valid_o, 1'b1);
    chk("m_req_addr", mem_req_addr_o, 20'h01000);
    chk("m_count", miss_count_o, 16'd1);
    chk("m_valid0", fetch_valid_o, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("m_req_hold", mem_req_valid_o, 1'b1);
      chk("m_addr_hold", mem_req_addr_o, 20'h01000);
    end
    mem_req_ready_i = 1'b1; step(); mem_req_ready_i = 1'b0;
    chk("m_req_drop", mem_req_valid_o, 1'b0);
    for (int i = 0; i < 2; i++) begin step(); chk("m_no_fill", fill_o, 1'b0); end
    mem_resp_valid_i = 1'b1; mem_resp_data_i = d_line; step(); mem_resp_valid_i = 1'b0;
    chk("m_fill", fill_o, 1'b1);
    chk("m_fill_addr", fill_addr_o, 20'h01000);
    chk("m_fill_data", fill_data_o, d_line);
    step();
    chk("m_fill_pulse", fill_o, 1'b0);
    chk("m_replay_pc", pc_o, 20'h01008);
    instr_i = 32'hCAFE0001; step();
    chk("m_after_valid", fetch_valid_o, 1'b1);
    chk("m_after_fpc", fetch_pc_o, 20'h01008);
    chk("m_after_instr", fetch_instr_o, 32'hCAFE0001);

    // redirect during MISS_WAIT: refill completes, then target taken
    cache_hit_i = 1'b0; step(); cache_hit_i = 1'b1;
    chk("w_count", miss_count_o, 16'd2);
    mem_req_ready_i = 1'b1; step(); mem_req_ready_i = 1'b0;
    redirect_valid_i = 1'b1; redirect_pc_i = 20'h03000; step(); redirect_valid_i = 1'b0;
    chk("w_pc_hold", pc_o, 20'h0100C);
    chk("w_no_fill", fill_o, 1'b0);
    mem_resp_valid_i = 1'b1; mem_resp_data_i = e_line; step(); mem_resp_valid_i = 1'b0;
    chk("w_fill", fill_o, 1'b1);
    chk("w_fill_data", fill_data_o, e_line);
    step();
    chk("w_pc_redir", pc_o, 20'h03000);
    step();
    chk("w_valid", fetch_valid_o, 1'b1);
    chk("w_fpc", fetch_pc_o, 20'h03000);

    // redirect in MISS_REQ drops the request
    cache_hit_i = 1'b0; step(); cache_hit_i = 1'b1;
    chk("q_req", mem_req_valid_o, 1'b1);
    chk("q_addr", mem_req_addr_o, 20'h03000);
    redirect_valid_i = 1'b1; redirect_pc_i = 20'h04000; step(); redirect_valid_i = 1'b0;
    chk("q_req_drop", mem_req_valid_o, 1'b0);
    chk("q_pc", pc_o, 20'h04000);
    step();
    chk("q_fpc", fetch_pc_o, 20'h04000);
    chk("q_count", miss_count_o, 16'd3);

    // I-TLB fault at 0x01010, frozen for 10 cycles, resume via redirect
    redirect_valid_i = 1'b1; redirect_pc_i = 20'h01010; step(); redirect_valid_i = 1'b0;
    priv_i = 1'b0; tlb_hit_i = 1'b0; step(); tlb_hit_i = 1'b1;
    chk("f_pulse", itlb_fault_o, 1'b1);
    chk("f_pc", fault_pc_o, 20'h01010);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("f_frozen", pc_o, 20'h01010);
      chk("f_no_repulse", itlb_fault_o, 1'b0);
      chk("f_valid0", fetch_valid_o, 1'b0);
    end
    redirect_valid_i = 1'b1; redirect_pc_i = 20'h02000; step(); redirect_valid_i = 1'b0;
    chk("f_resume_pc", pc_o, 20'h02000);
    priv_i = 1'b1; instr_i = 32'h12345678; step();
    chk("f_resume_fpc", fetch_pc_o, 20'h02000);
    chk("f_fault_pc_held", fault_pc_o, 20'h01010);

    // stall alone holds everything; stall + redirect takes the redirect
    stall_i = 1'b1; instr_i = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("s_pc", pc_o, 20'h02004);
      chk("s_valid", fetch_valid_o, 1'b1);
      chk("s_fpc", fetch_pc_o, 20'h02000);
      chk("s_instr", fetch_instr_o, 32'h12345678);
    end
    redirect_valid_i = 1'b1; redirect_pc_i = 20'h06000; step();
    redirect_valid_i = 1'b0; stall_i = 1'b0;
    chk("s_redir_pc", pc_o, 20'h06000);
    chk("s_redir_valid", fetch_valid_o, 1'b0);

    // reset asserted in MISS_WAIT abandons the refill
    cache_hit_i = 1'b0; step(); cache_hit_i = 1'b1;
    mem_req_ready_i = 1'b1; step(); mem_req_ready_i = 1'b0;
    reset_n = 1'b0; mem_resp_valid_i = 1'b1; step();
    reset_n = 1'b1; mem_resp_valid_i = 1'b0;
    chk("x_pc", pc_o, 20'h01000);
    chk("x_req", mem_req_valid_o, 1'b0);
    chk("x_fill", fill_o, 1'b0);
    chk("x_count", miss_count_o, 16'd0);
    chk("x_valid", fetch_valid_o, 1'b0);

    // random traffic against the reference model
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      model_check();
      priv_i           = ($urandom_range(1) == 0);
      stall_i          = ($urandom_range(4) == 0);
      redirect_valid_i = ($urandom_range(9) == 0);
      redirect_pc_i    = 20'($urandom) & 20'hFFFFC;
      tlb_hit_i        = ($urandom_range(9) != 0);
      cache_hit_i      = ($urandom_range(6) != 0);
      instr_i          = $urandom;
      mem_req_ready_i  = ($urandom_range(1) == 0);
      mem_resp_valid_i = ($urandom_range(2) == 0);
      mem_resp_data_i  = {$urandom, $urandom, $urandom, $urandom};
      model_step();
      step();
    end
    model_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
